usb_rx_bit_unstuffer: RTL and testbench

//  Receive-side counterpart of the transmit bit stuffer: removes the stuffed 0 inserted after

---
 rtl/usb_rx_pkg.sv | 13 +
 rtl/usb_rx_ones_counter.sv | 29 ++
 rtl/usb_rx_bit_unstuffer.sv | 124 ++++++++++++
 tb/tb_usb_rx_bit_unstuffer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB receive-path bit unstuffer.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    STRIP = 2'd2,
    ERROR = 2'd3
  } unstuff_state_t;

  localparam int USB_STUFF_LEN = 6;

endpackage

// File: rtl/usb_rx_ones_counter.sv
// Saturating run-of-ones counter used by the bit unstuffer.
// clr has priority over inc; the count never wraps past LIMIT.
module usb_rx_ones_counter #(
  parameter int LIMIT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] cnt,
  output logic       at_limit
);

  localparam logic [3:0] LIMIT_V = 4'(LIMIT);

  assign at_limit = (cnt == LIMIT_V);

  // Count consecutive ones, holding at LIMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/usb_rx_bit_unstuffer.sv
// USB receive bit unstuffer: forwards NRZI-decoded data bits, drops the
// stuffed 0 that follows STUFF_LEN ones, and flags a sticky stuff violation.
// Optional build macro UNSTUFF_STATS_EN adds the stuff_count output, the
// number of stuffed bits removed in the current packet (saturating).
module usb_rx_bit_unstuffer
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_en,
  input  logic       d_in,
  input  logic       rcving,
  input  logic       d_eop,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       strip_pulse,
  output logic       stuff_err
`ifdef UNSTUFF_STATS_EN
  ,
  output logic [7:0] stuff_count
`endif
);

  localparam logic [3:0] LIMIT_M1 = 4'(STUFF_LEN - 1);

  unstuff_state_t state;
  logic [3:0]     ones_cnt;
  logic           at_limit;
  logic           pkt_end;
  logic           pkt_start;
  logic           take_data;
  logic           reach_limit;
  logic           strip_now;
  logic           viol_now;
  logic           cnt_clr;
  logic           cnt_inc;

  // Packet end wins over any bit sampled in the same cycle
  assign pkt_end     = d_eop || !rcving;
  assign pkt_start   = (state == IDLE) && !pkt_end;
  assign take_data   = !pkt_end && (state == COUNT) && shift_en;
  assign reach_limit = take_data && d_in && (ones_cnt == LIMIT_M1);
  // In STRIP the counter sits at its limit, so a 1 here is a missing stuffed 0
  assign viol_now    = !pkt_end && (state == STRIP) && shift_en && d_in && at_limit;
  assign strip_now   = !pkt_end && (state == STRIP) && shift_en && !viol_now;

  assign cnt_clr = pkt_end || (state == IDLE) || (take_data && !d_in) || strip_now;
  assign cnt_inc = take_data && d_in;

  usb_rx_ones_counter #(
    .LIMIT (STUFF_LEN)
  ) u_ones (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .cnt      (ones_cnt),
    .at_limit (at_limit)
  );

  // Unstuff FSM with registered strobes, data bit and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      strip_pulse <= 1'b0;
      stuff_err   <= 1'b0;
    end else begin
      bit_valid   <= 1'b0;
      strip_pulse <= 1'b0;
      if (pkt_end) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            state     <= COUNT;
            stuff_err <= 1'b0;
          end
          COUNT: begin
            if (take_data) begin
              bit_valid <= 1'b1;
              bit_out   <= d_in;
              if (reach_limit) begin
                state <= STRIP;
              end
            end
          end
          STRIP: begin
            if (viol_now) begin
              stuff_err <= 1'b1;
              state     <= ERROR;
            end else if (strip_now) begin
              strip_pulse <= 1'b1;
              state       <= COUNT;
            end
          end
          ERROR: begin
            state <= ERROR;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef UNSTUFF_STATS_EN
  // Per-packet count of removed stuffed bits, saturating at 8'hFF
  always_ff @(posedge clk) begin
    if (rst) begin
      stuff_count <= 8'd0;
    end else if (pkt_start) begin
      stuff_count <= 8'd0;
    end else if (strip_now && (stuff_count != 8'hFF)) begin
      stuff_count <= stuff_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_rx_bit_unstuffer.sv
// Directed self-checking bench for usb_rx_bit_unstuffer (STUFF_LEN = 6).
// Build with UNSTUFF_STATS_EN defined to also exercise stuff_count.
module tb_usb_rx_bit_unstuffer;
  import usb_rx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic shift_en = 1'b0;
  logic d_in = 1'b0;
  logic rcving = 1'b0;
  logic d_eop = 1'b0;
  logic bit_out, bit_valid, strip_pulse, stuff_err;
`ifdef UNSTUFF_STATS_EN
  logic [7:0] stuff_count;
`endif

  int checks = 0;
  int errors = 0;

  usb_rx_bit_unstuffer #(.STUFF_LEN(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .shift_en    (shift_en),
    .d_in        (d_in),
    .rcving      (rcving),
    .d_eop       (d_eop),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .strip_pulse (strip_pulse),
    .stuff_err   (stuff_err)
`ifdef UNSTUFF_STATS_EN
    ,
    .stuff_count (stuff_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit period: strobe for a cycle, capture the registered result, then a gap cycle
  task automatic send_bit(input logic b, output logic v, output logic s, output logic o);
    shift_en = 1'b1;
    d_in     = b;
    tick();
    v = bit_valid;
    s = strip_pulse;
    o = bit_out;
    shift_en = 1'b0;
    tick();
  endtask

  task automatic start_pkt();
    rcving = 1'b1;
    d_eop  = 1'b0;
    tick();
  endtask

  task automatic end_pkt();
    d_eop = 1'b1;
    tick();
    d_eop  = 1'b0;
    rcving = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; rcving = 1'b1; shift_en = 1'b1; d_in = 1'b1;
    tick(); tick();
    checks++;
    if (bit_out !== 1'b0 || bit_valid !== 1'b0 || strip_pulse !== 1'b0 || stuff_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out=%b valid=%b strip=%b err=%b, want all 0",
               bit_out, bit_valid, strip_pulse, stuff_err);
    end
    checks++;
    if (dut.state !== IDLE || dut.ones_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d ones=%0d, want 0 0", dut.state, dut.ones_cnt);
    end
`ifdef UNSTUFF_STATS_EN
    checks++;
    if (stuff_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count: stuff_count=%0d, want 0", stuff_count);
    end
`endif
    rst = 1'b0; rcving = 1'b0; shift_en = 1'b0; d_in = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic v, s, o;
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    start_pkt();
    for (int i = 0; i < 5; i++) begin
      send_bit(pat[i], v, s, o);
      checks++;
      if (v !== 1'b1 || o !== pat[i] || s !== 1'b0) begin
        errors++;
        $display("FAIL basic_bit%0d: valid=%b out=%b strip=%b, want 1 %b 0", i, v, o, s, pat[i]);
      end
    end
    checks++;
    if (stuff_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_err: stuff_err=%b, want 0", stuff_err);
    end
    end_pkt();
  endtask

  task automatic test_strip();
    logic v, s, o;
    int nvalid = 0;
    start_pkt();
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b1, v, s, o);
      if (v === 1'b1 && o === 1'b1 && s === 1'b0) nvalid++;
    end
    checks++;
    if (nvalid != 6) begin
      errors++;
      $display("FAIL strip_ones: valid ones=%0d, want 6", nvalid);
    end
    send_bit(1'b0, v, s, o);
    checks++;
    if (v !== 1'b0 || s !== 1'b1 || o !== 1'b1) begin
      errors++;
      $display("FAIL strip_pulse: valid=%b strip=%b out=%b, want 0 1 1", v, s, o);
    end
    send_bit(1'b1, v, s, o);
    checks++;
    if (v !== 1'b1 || o !== 1'b1 || s !== 1'b0) begin
      errors++;
      $display("FAIL strip_trailing: valid=%b out=%b strip=%b, want 1 1 0", v, o, s);
    end
`ifdef UNSTUFF_STATS_EN
    checks++;
    if (stuff_count !== 8'd1) begin
      errors++;
      $display("FAIL strip_count: stuff_count=%0d, want 1", stuff_count);
    end
`endif
    end_pkt();
  endtask

  task automatic test_error();
    logic v, s, o;
    int nvalid = 0;
    start_pkt();
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b1, v, s, o);
      if (v === 1'b1) nvalid++;
    end
    send_bit(1'b1, v, s, o);
    checks++;
    if (nvalid != 6 || v !== 1'b0 || s !== 1'b0 || stuff_err !== 1'b1) begin
      errors++;
      $display("FAIL err_detect: valid6=%0d v7=%b s7=%b err=%b, want 6 0 0 1", nvalid, v, s, stuff_err);
    end
    nvalid = 0;
    for (int i = 0; i < 4; i++) begin
      send_bit(i[0], v, s, o);
      if (v !== 1'b0 || s !== 1'b0) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL err_ignore: strobes after violation=%0d, want 0", nvalid);
    end
    end_pkt();
    checks++;
    if (stuff_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: stuff_err=%b in idle, want 1", stuff_err);
    end
    start_pkt();
    checks++;
    if (stuff_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: stuff_err=%b after packet start, want 0", stuff_err);
    end
    end_pkt();
  endtask

  task automatic test_eop();
    logic v, s, o;
    start_pkt();
    send_bit(1'b1, v, s, o);
    send_bit(1'b1, v, s, o);
    shift_en = 1'b1; d_in = 1'b1; d_eop = 1'b1;
    tick();
    checks++;
    if (bit_valid !== 1'b0 || strip_pulse !== 1'b0 || dut.state !== IDLE || dut.ones_cnt !== 4'd0) begin
      errors++;
      $display("FAIL eop_collide: valid=%b strip=%b state=%0d ones=%0d, want 0 0 0 0",
               bit_valid, strip_pulse, dut.state, dut.ones_cnt);
    end
    shift_en = 1'b0; d_eop = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) send_bit(1'b1, v, s, o);
    checks++;
    if (dut.state !== STRIP) begin
      errors++;
      $display("FAIL eop_reach_strip: state=%0d, want %0d", dut.state, STRIP);
    end
    end_pkt();
    checks++;
    if (stuff_err !== 1'b0 || dut.state !== IDLE || strip_pulse !== 1'b0) begin
      errors++;
      $display("FAIL eop_in_strip: err=%b state=%0d strip=%b, want 0 0 0", stuff_err, dut.state, strip_pulse);
    end
  endtask

  task automatic test_rst_mid();
    logic v, s, o;
    int nvalid = 0;
    start_pkt();
    for (int i = 0; i < 4; i++) send_bit(1'b1, v, s, o);
    rst = 1'b1; shift_en = 1'b1; d_in = 1'b1;
    tick();
    checks++;
    if (bit_out !== 1'b0 || bit_valid !== 1'b0 || strip_pulse !== 1'b0 || stuff_err !== 1'b0
        || dut.state !== IDLE || dut.ones_cnt !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid: out=%b valid=%b strip=%b err=%b state=%0d ones=%0d, want all 0",
               bit_out, bit_valid, strip_pulse, stuff_err, dut.state, dut.ones_cnt);
    end
    rst = 1'b0; shift_en = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b1, v, s, o);
      if (v === 1'b1 && s === 1'b0) nvalid++;
    end
    checks++;
    if (nvalid != 6) begin
      errors++;
      $display("FAIL rst_fresh_ones: valid ones=%0d, want 6", nvalid);
    end
    send_bit(1'b0, v, s, o);
    checks++;
    if (s !== 1'b1 || v !== 1'b0) begin
      errors++;
      $display("FAIL rst_fresh_strip: strip=%b valid=%b, want 1 0", s, v);
    end
    end_pkt();
  endtask

  task automatic test_back_to_back();
    logic v, s, o;
    int nvalid = 0;
    int nstrip = 0;
    start_pkt();
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 6; j++) begin
        send_bit(1'b1, v, s, o);
        if (v === 1'b1) nvalid++;
        if (s === 1'b1) nstrip++;
      end
      send_bit(1'b0, v, s, o);
      if (v === 1'b1) nvalid++;
      if (s === 1'b1) nstrip++;
`ifdef UNSTUFF_STATS_EN
      if (i == 253) begin
        checks++;
        if (stuff_count !== 8'hFE) begin
          errors++;
          $display("FAIL stats_254: stuff_count=%0d, want 254", stuff_count);
        end
      end
`endif
    end
    checks++;
    if (nvalid != 1800 || nstrip != 300) begin
      errors++;
      $display("FAIL b2b_totals: valid=%0d strips=%0d, want 1800 300", nvalid, nstrip);
    end
`ifdef UNSTUFF_STATS_EN
    checks++;
    if (stuff_count !== 8'hFF) begin
      errors++;
      $display("FAIL stats_sat: stuff_count=%0d, want 255", stuff_count);
    end
`endif
    end_pkt();
`ifdef UNSTUFF_STATS_EN
    checks++;
    if (stuff_count !== 8'hFF) begin
      errors++;
      $display("FAIL stats_hold: stuff_count=%0d in idle, want 255", stuff_count);
    end
    start_pkt();
    checks++;
    if (stuff_count !== 8'd0) begin
      errors++;
      $display("FAIL stats_clear: stuff_count=%0d after packet start, want 0", stuff_count);
    end
    end_pkt();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strip();
    test_error();
    test_eop();
    test_rst_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
